// File: rtl/adder_share_arb_pkg.sv
// Shared types and the round-robin pick function for the adder-sharing arbiter.
package adder_share_pkg;

  localparam int MAX_N = 16;
  localparam int PTR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid searching upward from pointer+1, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] valid,
                                       input logic [PTR_W-1:0] pointer,
                                       input int unsigned      n);
    rr_pick_t         r;
    int unsigned      pos;
    logic [PTR_W-1:0] cand;
    r = '0;
    for (int unsigned k = 1; k <= MAX_N; k++) begin
      if (k <= n && !r.found) begin
        pos  = {28'd0, pointer} + k;
        cand = PTR_W'(pos % n);
        if (valid[cand]) begin
          r.found = 1'b1;
          r.idx   = cand;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// Requester and response handshake bundle between producers and the shared adder arbiter.
interface adder_share_arb_if #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W:0]     rsp_sum;
  logic [IDW-1:0] rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );

endinterface

// File: rtl/adder_share_arb_adder.sv
// Registered unsigned adder with a carry-out bit; deliberately has no reset.
module simple_adder #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  always_ff @(posedge clk) begin
    sum <= {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares one registered adder among N requesters.
//   state   | meaning
//   IDLE    | arbitrate; grant one requester and capture its operands
//   LOAD    | operand regs drive the adder, which registers the sum this cycle
//   RESP    | present sum and id until downstream accepts
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  adder_share_arb_if.slave bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             rsp_valid_q;
  logic [W:0]       sum;

  logic [MAX_N-1:0] valid_ext;
  logic [PTR_W-1:0] ptr_ext;
  rr_pick_t         pick;
  logic [IDW-1:0]   pick_idx;
  logic [N-1:0]     grant;

  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = bus.req_valid;
    ptr_ext            = '0;
    ptr_ext[IDW-1:0]   = ptr;
    pick               = rr_pick(valid_ext, ptr_ext, N);
    pick_idx           = pick.idx[IDW-1:0];
    grant              = '0;
    if (state == ST_IDLE && pick.found)
      grant[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= IDW'(N - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick.found) begin
            a_q   <= bus.req_a[pick_idx*W +: W];
            b_q   <= bus.req_b[pick_idx*W +: W];
            id_q  <= pick_idx;
            ptr   <= pick_idx;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          rsp_valid_q <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand regs stay put through RESP, so the free-running adder output is stable.
  simple_adder #(.W(W)) SA (
    .clk (clk),
    .a   (a_q),
    .b   (b_q),
    .sum (sum)
  );

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum;
  assign bus.rsp_id    = id_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_grant_idle_only: assert property (@(posedge clk) disable iff (rst)
                                      (state != ST_IDLE) |-> (grant == '0));

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb with N=4, W=4 and hand-computed expectations.
module tb_adder_share_arb;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  adder_share_arb_if #(.N(4), .W(4)) bus ();

  adder_share_arb #(.N(4), .W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[i*4 +: 4] = a;
    bus.req_b[i*4 +: 4] = b;
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.req_a = '0;
    bus.req_b = '0;
    apply_reset();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", bus.rsp_valid);
    end
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
    end
    checks++;
    if (bus.rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id);
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_op(2, 4'd7, 4'd9);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL single_load: got valid=%0b ready=%b expected 0 0000",
                         bus.rsp_valid, bus.req_ready);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 5'd16 || bus.rsp_id !== 2'd2) begin
      errors++; $display("FAIL single_resp: got valid=%0b sum=%0d id=%0d expected 1 16 2",
                         bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: got valid=%0b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] av [2];
    logic [4:0] exp_sum [2];
    av[0] = 4'd15; exp_sum[0] = 5'd30;
    av[1] = 4'd0;  exp_sum[1] = 5'd0;
    apply_reset();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_op(0, av[k], av[k]);
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = '0;
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== exp_sum[k] || bus.rsp_id !== 2'd0) begin
        errors++; $display("FAIL overflow_%0d: got valid=%0b sum=%0d id=%0d expected 1 %0d 0",
                           k, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, exp_sum[k]);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    logic [3:0] exp_ready;
    apply_reset();
    for (int i = 0; i < 4; i++) set_op(i, 4'(i), 4'd1);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_id    = 2'(k % 4);
      exp_ready = 4'b0001 << exp_id;
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, bus.req_ready, exp_ready);
      end
      step();
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id || bus.rsp_sum !== 5'(exp_id + 1)) begin
        errors++; $display("FAIL rr_resp_%0d: got valid=%0b id=%0d sum=%0d expected 1 %0d %0d",
                           k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, exp_id, exp_id + 1);
      end
      step();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_op(2, 4'd5, 4'd6);
    set_op(3, 4'd1, 4'd2);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 5'd11 || bus.rsp_id !== 2'd2 ||
          bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%0b sum=%0d id=%0d ready=%b expected 1 11 2 0000",
                           k, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.req_ready);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_next_grant: got valid=%0b ready=%b expected 0 1000",
                         bus.rsp_valid, bus.req_ready);
    end
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = '0;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 5'd3 || bus.rsp_id !== 2'd3) begin
      errors++; $display("FAIL bp_next_resp: got valid=%0b sum=%0d id=%0d expected 1 3 3",
                         bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
    end
    step();
  endtask

  task automatic test_reset_midop();
    apply_reset();
    for (int i = 0; i < 4; i++) set_op(i, 4'(i), 4'd1);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL midop_load_rst: got valid=%0b ready=%b expected 0 0001",
                         bus.rsp_valid, bus.req_ready);
    end
    bus.rsp_ready = 1'b0;
    step();
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 5'd1) begin
      errors++; $display("FAIL midop_resp: got valid=%0b id=%0d sum=%0d expected 1 0 1",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL midop_resp_rst: got valid=%0b ready=%b expected 0 0001",
                         bus.rsp_valid, bus.req_ready);
    end
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_withdrawal();
    apply_reset();
    set_op(0, 4'd1, 4'd1);
    set_op(1, 4'd4, 4'd4);
    set_op(3, 4'd6, 4'd7);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = '0;
    step();
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL wd_resp_ready: got %b expected 0000", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    step();
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wd_not_latched: got ready=%b valid=%0b expected 0000 0",
                         bus.req_ready, bus.rsp_valid);
    end
    bus.req_valid = 4'b1000;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL wd_grant3: got %b expected 1000", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_sum !== 5'd13) begin
      errors++; $display("FAIL wd_resp3: got valid=%0b id=%0d sum=%0d expected 1 3 13",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
    step();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_withdrawal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
